// File: rtl/bpsk_slicer_pkg.sv
// bpsk_slicer_pkg: shared definitions for the BPSK bit slicer.
//   slicer_state_e : control states WAIT_LOCK / SETTLE / RUN
//   DECIDE_NONNEG  : bit value emitted for a symbol sum >= 0
//   acc_width()    : accumulator width that cannot overflow over one symbol
package bpsk_slicer_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } slicer_state_e;

  localparam logic DECIDE_NONNEG = 1'b1;

  function automatic int unsigned acc_width(input int unsigned data_w,
                                            input int unsigned sps);
    return data_w + $clog2(sps) + 1;
  endfunction

endpackage

// File: rtl/bit_fifo.sv
// bit_fifo: small synchronous FIFO, async active-low reset.
//   clk_i, rst_ni       : clock, asynchronous active-low reset
//   push_i, data_i      : write strobe and data (caller must not push when full without popping)
//   pop_i               : read strobe (caller must not pop when empty)
//   data_o              : word at head
//   full_o, empty_o     : occupancy flags
module bit_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned    AW       = $clog2(DEPTH);
  localparam logic [AW-1:0]  PTR_ONE  = 1;
  localparam logic [AW:0]    CNT_ONE  = 1;
  localparam logic [AW:0]    FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;

  always_comb begin
    count_d = count_q;
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/bpsk_bit_slicer.sv
// bpsk_bit_slicer: integrate-and-dump hard BPSK slicer with lock settle gate
// and a buffered valid/ready bit output.
//   clk_main, rst_n      : clock, asynchronous active-low reset
//   in_vld, i_data,
//   q_data, locked_i     : sample stream and Costas lock flag (q_data unused)
//   bit_o, bit_vld_o,
//   bit_rdy_i            : output bit handshake, FIFO head
//   run_o                : high while slicing
//   overflow_o           : sticky, a bit was dropped on a full FIFO
// Optional macro BPSK_SLICER_DIFF_EN: differential decoding (bit = d ^ previous d).
module bpsk_bit_slicer
  import bpsk_slicer_pkg::*;
#(
  parameter int unsigned SAMPLES_PER_SYM = 16,
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned LOCK_HOLD       = 64,
  parameter int unsigned FIFO_DEPTH      = 8
) (
  input  logic                  clk_main,
  input  logic                  rst_n,
  input  logic                  in_vld,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [DATA_WIDTH-1:0] q_data,
  input  logic                  locked_i,
  output logic                  bit_o,
  output logic                  bit_vld_o,
  input  logic                  bit_rdy_i,
  output logic                  run_o,
  output logic                  overflow_o
);

  localparam int unsigned ACC_W  = acc_width(DATA_WIDTH, SAMPLES_PER_SYM);
  localparam int unsigned SCNT_W = $clog2(SAMPLES_PER_SYM);
  localparam int unsigned LCNT_W = $clog2(LOCK_HOLD + 1);

  localparam logic [SCNT_W-1:0] LAST_SAMPLE = SCNT_W'(SAMPLES_PER_SYM - 1);
  localparam logic [SCNT_W-1:0] SCNT_ONE    = 1;
  localparam logic [LCNT_W-1:0] HOLD_CNT    = LCNT_W'(LOCK_HOLD);
  localparam logic [LCNT_W-1:0] LCNT_ONE    = 1;

  slicer_state_e     state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic [LCNT_W-1:0] lcnt_q, lcnt_d;
  // Only the sign of the dumped sum is ever consulted, so that is all we keep.
  logic              sum_neg_q, sum_neg_d;
  logic              dump_q, dump_d;
  logic              ovf_q, ovf_d;
  logic              enter_run;

  logic [ACC_W-1:0]  sample_ext;
  logic [ACC_W-1:0]  sum_now;
  logic              decision;
  logic              push_bit;
  logic              fifo_full, fifo_empty, fifo_head;
  logic              pop, push_ok, drop;

  logic              unused_q;
  assign unused_q = ^q_data;

  assign sample_ext = {{(ACC_W - DATA_WIDTH){i_data[DATA_WIDTH-1]}}, i_data};
  assign sum_now    = acc_q + sample_ext;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    scnt_d    = scnt_q;
    lcnt_d    = lcnt_q;
    sum_neg_d = sum_neg_q;
    dump_d    = 1'b0;
    enter_run = 1'b0;
    if (in_vld) begin
      unique case (state_q)
        WAIT_LOCK: begin
          if (locked_i) begin
            lcnt_d = LCNT_ONE;
            if (LOCK_HOLD == 1) begin
              state_d   = RUN;
              enter_run = 1'b1;
            end else begin
              state_d = SETTLE;
            end
          end
        end
        SETTLE: begin
          if (locked_i) begin
            lcnt_d = lcnt_q + LCNT_ONE;
            if (lcnt_q + LCNT_ONE == HOLD_CNT) begin
              state_d   = RUN;
              enter_run = 1'b1;
            end
          end else begin
            lcnt_d  = '0;
            state_d = WAIT_LOCK;
          end
        end
        RUN: begin
          if (locked_i) begin
            if (scnt_q == LAST_SAMPLE) begin
              sum_neg_d = sum_now[ACC_W-1];
              dump_d    = 1'b1;
              acc_d     = '0;
              scnt_d    = '0;
            end else begin
              acc_d  = sum_now;
              scnt_d = scnt_q + SCNT_ONE;
            end
          end else begin
            acc_d   = '0;
            scnt_d  = '0;
            lcnt_d  = '0;
            state_d = WAIT_LOCK;
          end
        end
        default: state_d = WAIT_LOCK;
      endcase
    end
  end

  assign decision = DECIDE_NONNEG ^ sum_neg_q;

`ifdef BPSK_SLICER_DIFF_EN
  logic ref_q, ref_d;

  assign push_bit = decision ^ ref_q;

  always_comb begin
    ref_d = ref_q;
    if (enter_run)   ref_d = 1'b0;
    else if (dump_q) ref_d = decision;
  end

  always_ff @(posedge clk_main or negedge rst_n) begin
    if (!rst_n) ref_q <= 1'b0;
    else        ref_q <= ref_d;
  end
`else
  logic unused_enter_run;
  assign unused_enter_run = enter_run;
  assign push_bit = decision;
`endif

  assign pop     = !fifo_empty && bit_rdy_i;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push_ok = dump_q && (!fifo_full || pop);
  assign drop    = dump_q && fifo_full && !pop;
  assign ovf_d   = ovf_q | drop;

  always_ff @(posedge clk_main or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WAIT_LOCK;
      acc_q     <= '0;
      scnt_q    <= '0;
      lcnt_q    <= '0;
      sum_neg_q <= 1'b0;
      dump_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      scnt_q    <= scnt_d;
      lcnt_q    <= lcnt_d;
      sum_neg_q <= sum_neg_d;
      dump_q    <= dump_d;
      ovf_q     <= ovf_d;
    end
  end

  bit_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (1)
  ) u_fifo (
    .clk_i   (clk_main),
    .rst_ni  (rst_n),
    .push_i  (push_ok),
    .data_i  (push_bit),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bit_o      = !fifo_empty && fifo_head;
  assign bit_vld_o  = !fifo_empty;
  assign run_o      = (state_q == RUN);
  assign overflow_o = ovf_q;

endmodule
